// File: rtl/dot_pkg.sv
// Shared types and helpers for the dot-product accumulator stage.
package dot_pkg;

    typedef enum logic {ST_EMPTY, ST_FULL} dot_acc_state_t;

    function automatic int unsigned acc_width_f(int unsigned in_w, int unsigned n);
        return in_w + $clog2(n);
    endfunction

endpackage

// File: rtl/dot_acc_int_if.sv
// Beat-in / result-out handshake bundle for dot_acc_int.
interface dot_acc_int_if
    import dot_pkg::*;
#(
    parameter int unsigned in_width   = 21,
    parameter int unsigned max_blocks = 64,
    parameter int unsigned acc_width  = acc_width_f(in_width, max_blocks)
);
    localparam int unsigned cnt_width = $clog2(max_blocks + 1);

    logic                        i_valid;
    logic                        o_ready;
    logic signed [in_width-1:0]  i_dp;
    logic                        i_last;
    logic                        o_valid;
    logic                        i_ready;
    logic signed [acc_width-1:0] o_acc;
    logic [cnt_width-1:0]        o_cnt;
    logic                        o_ovf;

    modport slave (
        input  i_valid, i_dp, i_last, i_ready,
        output o_ready, o_valid, o_acc, o_cnt, o_ovf
    );

    modport master (
        output i_valid, i_dp, i_last, i_ready,
        input  o_ready, o_valid, o_acc, o_cnt, o_ovf
    );

endinterface

// File: rtl/sat_add_int.sv
// Signed adder; saturates on overflow when DOT_ACC_SAT_EN is defined, wraps otherwise.
module sat_add_int #(
    parameter int unsigned width = 8
) (
    input  logic signed [width-1:0] a_i,
    input  logic signed [width-1:0] b_i,
    output logic signed [width-1:0] sum_o,
    output logic                    ovf_o
);

    logic signed [width-1:0] raw;

    always_comb begin
        raw   = a_i + b_i;
        ovf_o = (a_i[width-1] == b_i[width-1]) && (raw[width-1] != a_i[width-1]);
`ifdef DOT_ACC_SAT_EN
        if (ovf_o) begin
            sum_o = a_i[width-1] ? {1'b1, {(width-1){1'b0}}} : {1'b0, {(width-1){1'b1}}};
        end else begin
            sum_o = raw;
        end
`else
        sum_o = raw;
`endif
    end

endmodule

// File: rtl/dot_acc_int.sv
// Accumulates signed partial dot products per group and emits a registered group result.
// Optional DOT_ACC_SAT_EN: saturating accumulation with a clamp held for the rest of the group.
module dot_acc_int
    import dot_pkg::*;
#(
    parameter int unsigned in_width   = 21,
    parameter int unsigned max_blocks = 64,
    parameter int unsigned acc_width  = acc_width_f(in_width, max_blocks)
) (
    input logic         i_clk,
    input logic         i_rst,
    dot_acc_int_if.slave bus
);

    localparam int unsigned cnt_width = $clog2(max_blocks + 1);
    localparam logic [cnt_width-1:0] cnt_max = cnt_width'(max_blocks);

    dot_acc_state_t              state_q, state_d;
    logic signed [acc_width-1:0] acc_q, acc_d;
    logic [cnt_width-1:0]        cnt_q, cnt_d;
    logic                        ovf_q, ovf_d;
    logic signed [acc_width-1:0] res_acc_q, res_acc_d;
    logic [cnt_width-1:0]        res_cnt_q, res_cnt_d;
    logic                        res_ovf_q, res_ovf_d;

    logic                        accept;
    logic signed [acc_width-1:0] dp_ext;
    logic signed [acc_width-1:0] add_sum;
    logic                        add_ovf;
    logic signed [acc_width-1:0] sum;
    logic                        sum_ovf;
    logic [cnt_width-1:0]        cnt_inc;
    logic                        cnt_err;

    assign accept  = bus.i_valid && bus.o_ready;
    assign dp_ext  = acc_width'(bus.i_dp);
    assign cnt_err = (cnt_q == cnt_max);
    assign cnt_inc = cnt_err ? cnt_q : cnt_q + cnt_width'(1);

    sat_add_int #(
        .width (acc_width)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (dp_ext),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

`ifdef DOT_ACC_SAT_EN
    // Once a group has clamped, the accumulator is frozen at the clamp value.
    logic sat_q, sat_d;

    assign sum     = sat_q ? acc_q : add_sum;
    assign sum_ovf = sat_q | add_ovf;

    always_comb begin
        sat_d = sat_q;
        if (accept) begin
            sat_d = bus.i_last ? 1'b0 : sum_ovf;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
`else
    logic unused_add_ovf;

    assign unused_add_ovf = add_ovf;
    assign sum            = add_sum;
    assign sum_ovf        = 1'b0;
`endif

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        res_acc_d = res_acc_q;
        res_cnt_d = res_cnt_q;
        res_ovf_d = res_ovf_q;
        if (accept) begin
            if (bus.i_last) begin
                res_acc_d = sum;
                res_cnt_d = cnt_inc;
                res_ovf_d = ovf_q | cnt_err | sum_ovf;
                acc_d     = '0;
                cnt_d     = '0;
                ovf_d     = 1'b0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_inc;
                ovf_d = ovf_q | cnt_err | sum_ovf;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_EMPTY;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_acc_q <= '0;
            res_cnt_q <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            res_acc_q <= res_acc_d;
            res_cnt_q <= res_cnt_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    // A new last beat reloads FULL directly, so draining and refilling needs no bubble.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (accept && bus.i_last) state_d = ST_FULL;
            ST_FULL: begin
                if (accept && bus.i_last) begin
                    state_d = ST_FULL;
                end else if (bus.i_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        bus.o_valid = (state_q == ST_FULL);
        bus.o_ready = (state_q == ST_EMPTY) || bus.i_ready;
    end

    assign bus.o_acc = res_acc_q;
    assign bus.o_cnt = res_cnt_q;
    assign bus.o_ovf = res_ovf_q;

endmodule

// File: tb/tb_dot_acc_int.sv
// Self-checking bench for dot_acc_int: directed scenarios plus a randomized scoreboard run.
module tb_dot_acc_int;

    localparam int unsigned IW = 8;
    localparam int unsigned MB = 4;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dot_acc_int_if #(.in_width(IW), .max_blocks(MB), .acc_width(AW)) bus ();

    dot_acc_int #(
        .in_width   (IW),
        .max_blocks (MB),
        .acc_width  (AW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int acc;
        int cnt;
        bit ovf;
    } res_t;

    res_t   expq[$];
    longint m_sum;
    int     m_n;
    bit     m_sat;

    function automatic int wrap_aw(longint x);
        longint m = longint'(1) << AW;
        longint r = x % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return int'(r);
    endfunction

    // Reference model: group sum in wide arithmetic, reduced to acc_width at the end.
    task automatic model_beat(input int v, input bit last);
        longint hi = (longint'(1) << (AW - 1)) - 1;
        longint lo = -(longint'(1) << (AW - 1));
        res_t   r;
`ifdef DOT_ACC_SAT_EN
        if (!m_sat) begin
            m_sum += v;
            if (m_sum > hi) begin m_sum = hi; m_sat = 1'b1; end
            if (m_sum < lo) begin m_sum = lo; m_sat = 1'b1; end
        end
`else
        m_sum += v;
        if (hi < lo) m_sat = 1'b1;
`endif
        m_n++;
        if (last) begin
            r.acc = wrap_aw(m_sum);
            r.cnt = (m_n > int'(MB)) ? int'(MB) : m_n;
            r.ovf = (m_n > int'(MB)) || m_sat;
            expq.push_back(r);
            m_sum = 0;
            m_n   = 0;
            m_sat = 1'b0;
        end
    endtask

    task automatic step(input bit v, input int dp, input bit last, input bit rdy,
                        output bit rdy_seen);
        bus.i_valid = v;
        bus.i_dp    = IW'(dp);
        bus.i_last  = last;
        bus.i_ready = rdy;
        #1;
        rdy_seen = bus.o_ready;
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.i_valid = 1'b0;
        bus.i_dp    = '0;
        bus.i_last  = 1'b0;
        bus.i_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_sum = 0;
        m_n   = 0;
        m_sat = 1'b0;
        expq.delete();
    endtask

    task automatic test_reset();
        bit r;
        rst = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_dp    = IW'(5);
        bus.i_last  = 1'b1;
        bus.i_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.o_valid !== 1'b0 || bus.o_acc !== '0 || bus.o_cnt !== '0 || bus.o_ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b acc=%0d cnt=%0d ovf=%b want 0/0/0/0",
                     bus.o_valid, bus.o_acc, bus.o_cnt, bus.o_ovf);
        end
        bus.i_valid = 1'b0;
        rst = 1'b0;
        step(1'b0, 0, 1'b0, 1'b0, r);
        total++;
        if (bus.o_valid !== 1'b0 || r !== 1'b1) begin
            bad++;
            $display("FAIL reset_no_accept: got o_valid=%b o_ready=%b want 0/1", bus.o_valid, r);
        end
    endtask

    task automatic test_basic_group();
        bit r;
        do_reset();
        step(1'b1, 5, 1'b0, 1'b1, r);
        step(1'b1, -3, 1'b0, 1'b1, r);
        step(1'b1, 10, 1'b1, 1'b1, r);
        total++;
        if (bus.o_valid !== 1'b1 || int'(bus.o_acc) !== 12 || int'(bus.o_cnt) !== 3 ||
            bus.o_ovf !== 1'b0) begin
            bad++;
            $display("FAIL basic_group: got v=%b acc=%0d cnt=%0d ovf=%b want 1/12/3/0",
                     bus.o_valid, $signed(bus.o_acc), bus.o_cnt, bus.o_ovf);
        end
        step(1'b0, 0, 1'b0, 1'b1, r);
        total++;
        if (bus.o_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_drain: got o_valid=%b want 0", bus.o_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit r0, r1, r2;
        do_reset();
        step(1'b1, 7, 1'b1, 1'b1, r0);
        total++;
        if (bus.o_valid !== 1'b1 || int'($signed(bus.o_acc)) !== 7) begin
            bad++;
            $display("FAIL b2b_first: got v=%b acc=%0d want 1/7", bus.o_valid, $signed(bus.o_acc));
        end
        step(1'b1, -2, 1'b0, 1'b1, r1);
        step(1'b1, -2, 1'b1, 1'b1, r2);
        total++;
        if (bus.o_valid !== 1'b1 || int'($signed(bus.o_acc)) !== -4 || int'(bus.o_cnt) !== 2) begin
            bad++;
            $display("FAIL b2b_second: got v=%b acc=%0d cnt=%0d want 1/-4/2",
                     bus.o_valid, $signed(bus.o_acc), bus.o_cnt);
        end
        total++;
        if ({r0, r1, r2} !== 3'b111) begin
            bad++;
            $display("FAIL b2b_ready: got o_ready=%b%b%b want 111", r0, r1, r2);
        end
    endtask

    task automatic test_stall();
        bit r;
        do_reset();
        step(1'b1, 1, 1'b1, 1'b1, r);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2, 1'b0, 1'b0, r);
            total++;
            if (r !== 1'b0 || bus.o_valid !== 1'b1 || int'(bus.o_acc) !== 1 ||
                int'(bus.o_cnt) !== 1) begin
                bad++;
                $display("FAIL stall_hold: got rdy=%b v=%b acc=%0d cnt=%0d want 0/1/1/1",
                         r, bus.o_valid, bus.o_acc, bus.o_cnt);
            end
        end
        step(1'b1, 2, 1'b0, 1'b1, r);
        total++;
        if (r !== 1'b1 || bus.o_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_release: got rdy=%b v=%b want 1/0", r, bus.o_valid);
        end
        step(1'b1, 3, 1'b1, 1'b1, r);
        total++;
        if (bus.o_valid !== 1'b1 || int'(bus.o_acc) !== 5 || int'(bus.o_cnt) !== 2) begin
            bad++;
            $display("FAIL stall_sum: got v=%b acc=%0d cnt=%0d want 1/5/2",
                     bus.o_valid, bus.o_acc, bus.o_cnt);
        end
    endtask

    task automatic test_count_ovf();
        bit r;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0, 1'b1, r);
        step(1'b1, 1, 1'b1, 1'b1, r);
        total++;
        if (int'(bus.o_acc) !== 5 || int'(bus.o_cnt) !== 4 || bus.o_ovf !== 1'b1) begin
            bad++;
            $display("FAIL count_ovf: got acc=%0d cnt=%0d ovf=%b want 5/4/1",
                     bus.o_acc, bus.o_cnt, bus.o_ovf);
        end
        step(1'b1, 2, 1'b1, 1'b1, r);
        total++;
        if (bus.o_valid !== 1'b1 || int'(bus.o_acc) !== 2 || int'(bus.o_cnt) !== 1 ||
            bus.o_ovf !== 1'b0) begin
            bad++;
            $display("FAIL count_ovf_next: got v=%b acc=%0d cnt=%0d ovf=%b want 1/2/1/0",
                     bus.o_valid, bus.o_acc, bus.o_cnt, bus.o_ovf);
        end
    endtask

    task automatic test_arith_ovf();
        bit r;
        int exp_acc;
        bit exp_ovf;
`ifdef DOT_ACC_SAT_EN
        exp_acc = 127;
        exp_ovf = 1'b1;
`else
        exp_acc = -56;
        exp_ovf = 1'b0;
`endif
        do_reset();
        step(1'b1, 100, 1'b0, 1'b1, r);
        step(1'b1, 100, 1'b1, 1'b1, r);
        total++;
        if (int'($signed(bus.o_acc)) !== exp_acc || bus.o_ovf !== exp_ovf) begin
            bad++;
            $display("FAIL arith_ovf: got acc=%0d ovf=%b want %0d/%b",
                     $signed(bus.o_acc), bus.o_ovf, exp_acc, exp_ovf);
        end
    endtask

    task automatic test_mid_reset();
        bit r;
        do_reset();
        step(1'b1, 3, 1'b0, 1'b1, r);
        step(1'b1, 4, 1'b0, 1'b1, r);
        bus.i_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 9, 1'b1, 1'b1, r);
        total++;
        if (bus.o_valid !== 1'b1 || int'(bus.o_acc) !== 9 || int'(bus.o_cnt) !== 1) begin
            bad++;
            $display("FAIL mid_reset: got v=%b acc=%0d cnt=%0d want 1/9/1",
                     bus.o_valid, bus.o_acc, bus.o_cnt);
        end
    endtask

    task automatic test_random();
        bit r;
        bit v, last, rdy, was_valid;
        int dp;
        res_t e;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v    = ($urandom_range(0, 9) < 8);
            rdy  = ($urandom_range(0, 9) < 7);
            last = ($urandom_range(0, 4) == 0);
            dp   = int'($urandom_range(0, 255)) - 128;
            was_valid = bus.o_valid;
            if (was_valid) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL rand_unexpected: got o_valid=1 want no pending result");
                end else begin
                    e = expq[0];
                    if (int'($signed(bus.o_acc)) !== e.acc || int'(bus.o_cnt) !== e.cnt ||
                        bus.o_ovf !== e.ovf) begin
                        bad++;
                        $display("FAIL rand_result: got acc=%0d cnt=%0d ovf=%b want %0d/%0d/%b",
                                 $signed(bus.o_acc), bus.o_cnt, bus.o_ovf, e.acc, e.cnt, e.ovf);
                    end
                end
            end
            step(v, dp, last, rdy, r);
            if (r !== (!was_valid || rdy)) begin
                total++;
                bad++;
                $display("FAIL rand_ready: got o_ready=%b want %b", r, !was_valid || rdy);
            end
            if (was_valid && rdy && expq.size() > 0) void'(expq.pop_front());
            if (v && r) model_beat(dp, last);
        end
    endtask

    initial begin
        fork
            begin
                #200000;
                $display("FAIL timeout: got no finish want finish before time limit");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_basic_group();
        test_back_to_back();
        test_stall();
        test_count_ovf();
        test_arith_ovf();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
